// File: rtl/servant_pkg.sv
// servant_pkg
//   Shared definitions for the PLL supervisor: state encodings, the FSM
//   state type, the lock-loss latency bound and a small sizing helper.
//   No ports.
package servant_pkg;

  localparam logic [2:0] ST_PLLRST = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_FILTER = 3'd2;
  localparam logic [2:0] ST_RELP   = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  typedef enum logic [2:0] {
    S_PLLRST = ST_PLLRST,
    S_WAIT   = ST_WAIT,
    S_FILTER = ST_FILTER,
    S_RELP   = ST_RELP,
    S_RUN    = ST_RUN,
    S_FAULT  = ST_FAULT
  } state_e;

  // i_locked fall to o_rst_core high: two synchronizer stages plus the
  // registered FSM decision.
  localparam int LOCK_LOSS_LATENCY = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/servant_sync2.sv
// servant_sync2
//   Two-flop synchronizer for a single asynchronous level.
//   Ports:
//     i_clk  destination clock
//     i_rst  synchronous active-high reset, clears both stages
//     i_d    asynchronous input
//     o_q    synchronized output
module servant_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/servant_pll_supervisor.sv
// servant_pll_supervisor
//   Sequences PLL reset, waits for a filtered lock, then releases the
//   peripheral reset followed by the core reset after a stage delay.
//   Lock loss reasserts both domain resets and restarts the PLL; repeated
//   lock failures park the block in a sticky fault.
//   Ports:
//     i_clk         reference clock (also feeds the PLL)
//     i_rst         synchronous active-high reset
//     i_locked      PLL lock flag, asynchronous
//     o_pll_rst     PLL reset request
//     o_rst_periph  peripheral-domain reset
//     o_rst_core    core-domain reset
//     o_err         sticky lock-failure flag
//     o_relock_cnt  saturating RUN lock-loss count, only present when
//                   SERVANT_PLL_SUPERVISOR_STATUS_EN is defined
//
//   state  | meaning
//   PLLRST | hold PLL in reset for PLL_RST_CYCLES
//   WAIT   | wait up to LOCK_TIMEOUT cycles for lk
//   FILTER | require LOCK_FILTER consecutive lk cycles
//   RELP   | peripheral released, core held for STAGE_DELAY cycles
//   RUN    | both domains released
//   FAULT  | retries exhausted, everything held, exit only by i_rst
module servant_pll_supervisor
  import servant_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int LOCK_FILTER    = 256,
  parameter int STAGE_DELAY    = 64,
  parameter int MAX_RETRY      = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_locked,
  output logic       o_pll_rst,
  output logic       o_rst_periph,
  output logic       o_rst_core,
  output logic       o_err
`ifdef SERVANT_PLL_SUPERVISOR_STATUS_EN
  ,
  output logic [7:0] o_relock_cnt
`endif
);

  localparam int MAX_PARAM = max_int(max_int(max_int(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                             max_int(LOCK_FILTER, STAGE_DELAY)),
                                     MAX_RETRY);
  localparam int CNT_W = $clog2(MAX_PARAM) + 1;

  localparam logic [CNT_W-1:0] PLL_TC   = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_TC    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FLT_TC   = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] STG_TC   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] RETRY_TC = CNT_W'(MAX_RETRY);

  logic lk;

  servant_sync2 u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_locked),
    .o_q   (lk)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0] retry_inc;
  logic             pll_rst_q, pll_rst_d;
  logic             rst_periph_q, rst_periph_d;
  logic             rst_core_q, rst_core_d;
  logic             err_q, err_d;

  assign retry_inc = retry_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    case (state_q)
      S_PLLRST: begin
        if (cnt_q == PLL_TC) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (lk) begin
          state_d = S_FILTER;
          cnt_d   = '0;
        end else if (cnt_q == TO_TC) begin
          retry_d = retry_inc;
          cnt_d   = '0;
          state_d = (retry_inc >= RETRY_TC) ? S_FAULT : S_PLLRST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FILTER: begin
        if (!lk) begin
          retry_d = retry_inc;
          cnt_d   = '0;
          state_d = (retry_inc >= RETRY_TC) ? S_FAULT : S_PLLRST;
        end else if (cnt_q == FLT_TC) begin
          state_d = S_RELP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELP: begin
        if (!lk) begin
          state_d = S_PLLRST;
          cnt_d   = '0;
        end else if (cnt_q == STG_TC) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!lk) begin
          state_d = S_PLLRST;
          cnt_d   = '0;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_PLLRST;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the next state so they change on the same edge as it.
    pll_rst_d    = (state_d == S_PLLRST) || (state_d == S_FAULT);
    rst_periph_d = !((state_d == S_RELP) || (state_d == S_RUN));
    rst_core_d   = (state_d != S_RUN);
    err_d        = (state_d == S_FAULT);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_PLLRST;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_rst_q    <= 1'b1;
      rst_periph_q <= 1'b1;
      rst_core_q   <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_rst_q    <= pll_rst_d;
      rst_periph_q <= rst_periph_d;
      rst_core_q   <= rst_core_d;
      err_q        <= err_d;
    end
  end

  assign o_pll_rst    = pll_rst_q;
  assign o_rst_periph = rst_periph_q;
  assign o_rst_core   = rst_core_q;
  assign o_err        = err_q;

`ifdef SERVANT_PLL_SUPERVISOR_STATUS_EN
  logic [7:0] relock_cnt_q, relock_cnt_d;

  always_comb begin
    relock_cnt_d = relock_cnt_q;
    if ((state_q == S_RUN) && !lk && (relock_cnt_q != 8'hFF)) begin
      relock_cnt_d = relock_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      relock_cnt_q <= 8'd0;
    end else begin
      relock_cnt_q <= relock_cnt_d;
    end
  end

  assign o_relock_cnt = relock_cnt_q;
`endif

endmodule

// File: tb/tb_servant_pll_supervisor.sv
module tb_servant_pll_supervisor;

  localparam int P_PLL   = 4;
  localparam int P_TO    = 20;
  localparam int P_FLT   = 8;
  localparam int P_STG   = 5;
  localparam int P_RETRY = 2;
  // i_locked edge to first FSM decision: two sync stages, then one edge
  // for WAIT to move into FILTER.
  localparam int SYNC_LAT = 2;
  localparam int LIMIT    = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic locked = 1'b0;
  logic o_pll_rst, o_rst_periph, o_rst_core, o_err;
`ifdef SERVANT_PLL_SUPERVISOR_STATUS_EN
  logic [7:0] relock_cnt;
`endif

  servant_pll_supervisor #(
    .PLL_RST_CYCLES (P_PLL),
    .LOCK_TIMEOUT   (P_TO),
    .LOCK_FILTER    (P_FLT),
    .STAGE_DELAY    (P_STG),
    .MAX_RETRY      (P_RETRY)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_locked     (locked),
    .o_pll_rst    (o_pll_rst),
    .o_rst_periph (o_rst_periph),
    .o_rst_core   (o_rst_core),
    .o_err        (o_err)
`ifdef SERVANT_PLL_SUPERVISOR_STATUS_EN
    ,
    .o_relock_cnt (relock_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int periph_low_cnt = 0;

  typedef struct {
    string tag;
    int    exp;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every cycle passes through here, so the core/periph ordering rule is
  // checked on all cycles of every scenario.
  task automatic tick();
    @(posedge clk);
    #1;
    total++;
    assert ((o_rst_core | ~o_rst_periph) === 1'b1) else begin
      bad++;
      $error("FAIL order observed core=%0b periph=%0b expected core=1 while periph=1",
             o_rst_core, o_rst_periph);
    end
    if (o_rst_periph === 1'b0) periph_low_cnt++;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return o_pll_rst;
      1:       return o_rst_periph;
      2:       return o_rst_core;
      default: return o_err;
    endcase
  endfunction

  task automatic wait_level(input int sel, input logic val, output int n);
    n = 0;
    while ((sig(sel) !== val) && (n < LIMIT)) begin
      tick();
      n++;
    end
  endtask

  task automatic sb_push(input string tag, input int exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic sb_check(input int obs);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty observed=%0d expected=queued entry", obs);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.exp);
    end
  endtask

  // Queue the expected cycle count, then pop it when the output moves.
  task automatic expect_edge(input string tag, input int sel, input logic val, input int exp);
    int n;
    sb_push(tag, exp);
    wait_level(sel, val, n);
    sb_check(n);
  endtask

  task automatic do_reset();
    locked = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int base;

    // reset state
    rst = 1'b1;
    locked = 1'b0;
    tick();
    tick();
    chk("rst_pll", o_pll_rst, 1);
    chk("rst_periph", o_rst_periph, 1);
    chk("rst_core", o_rst_core, 1);
    chk("rst_err", o_err, 0);
`ifdef SERVANT_PLL_SUPERVISOR_STATUS_EN
    chk("rst_relock", relock_cnt, 0);
`endif
    rst = 1'b0;

    // nominal bring-up, lock arrives 10 cycles after reset release
    expect_edge("nom_pll_fall", 0, 1'b0, P_PLL);
    repeat (10 - P_PLL) tick();
    locked = 1'b1;
    expect_edge("nom_periph_fall", 1, 1'b0, SYNC_LAT + 1 + P_FLT);
    chk("nom_core_held", o_rst_core, 1);
    expect_edge("nom_core_fall", 2, 1'b0, P_STG);
    chk("nom_run_pll", o_pll_rst, 0);
    chk("nom_run_err", o_err, 0);

    // lock loss in RUN and recovery
    repeat (3) tick();
    locked = 1'b0;
    expect_edge("loss_core_rise", 2, 1'b1, 3);
    chk("loss_periph", o_rst_periph, 1);
    chk("loss_pll", o_pll_rst, 1);
    expect_edge("loss_pll_fall", 0, 1'b0, P_PLL);
    locked = 1'b1;
    expect_edge("relock_periph_fall", 1, 1'b0, SYNC_LAT + 1 + P_FLT);
    expect_edge("relock_core_fall", 2, 1'b0, P_STG);
`ifdef SERVANT_PLL_SUPERVISOR_STATUS_EN
    chk("relock_cnt", relock_cnt, 1);
`endif

    // reset pulse while in RELP
    do_reset();
    expect_edge("mid_pll_fall", 0, 1'b0, P_PLL);
    locked = 1'b1;
    expect_edge("mid_periph_fall", 1, 1'b0, SYNC_LAT + 1 + P_FLT);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_pll", o_pll_rst, 1);
    chk("mid_rst_periph", o_rst_periph, 1);
    chk("mid_rst_core", o_rst_core, 1);
    chk("mid_rst_err", o_err, 0);
`ifdef SERVANT_PLL_SUPERVISOR_STATUS_EN
    chk("mid_rst_relock", relock_cnt, 0);
`endif
    rst = 1'b0;
    // locked already high: synced during PLLRST, WAIT leaves on its first cycle
    expect_edge("mid_restart_pll_fall", 0, 1'b0, P_PLL);
    expect_edge("mid_restart_periph_fall", 1, 1'b0, 1 + P_FLT);
    expect_edge("mid_restart_core_fall", 2, 1'b0, P_STG);

    // lock glitch during FILTER
    do_reset();
    expect_edge("gl_pll_fall", 0, 1'b0, P_PLL);
    base = periph_low_cnt;
    locked = 1'b1;
    repeat (5) tick();
    locked = 1'b0;
    expect_edge("gl_pll_rise", 0, 1'b1, 3);
    chk("gl_no_release", periph_low_cnt - base, 0);
    chk("gl_core", o_rst_core, 1);
    // retry is now 1, so a single timeout must reach FAULT
    expect_edge("gl_retry_pll_fall", 0, 1'b0, P_PLL);
    expect_edge("gl_retry_err", 3, 1'b1, P_TO);
    chk("gl_fault_pll", o_pll_rst, 1);
    chk("gl_fault_periph", o_rst_periph, 1);

    // lock never arrives
    do_reset();
    expect_edge("to_pll_fall1", 0, 1'b0, P_PLL);
    expect_edge("to_pll_rise", 0, 1'b1, P_TO);
    expect_edge("to_pll_fall2", 0, 1'b0, P_PLL);
    expect_edge("to_err_rise", 3, 1'b1, P_TO);
    chk("to_fault_pll", o_pll_rst, 1);
    chk("to_fault_periph", o_rst_periph, 1);
    chk("to_fault_core", o_rst_core, 1);
    locked = 1'b1;
    repeat (30) tick();
    chk("to_err_sticky", o_err, 1);
    chk("to_core_sticky", o_rst_core, 1);
    rst = 1'b1;
    tick();
    chk("to_rst_err_clear", o_err, 0);
    chk("to_rst_pll", o_pll_rst, 1);
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/servant_pll_supervisor.md
SERVANT_PLL_SUPERVISOR -- requirements
Module: servant_pll_supervisor

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, number of cycles o_pll_rst is held per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536, number of cycles to wait for lock before a retry.
REQ-003 SHALL have parameter LOCK_FILTER, default 256, number of consecutive synchronized-locked cycles required before lock is accepted.
REQ-004 SHALL have parameter STAGE_DELAY, default 64, number of cycles between peripheral and core reset release.
REQ-005 SHALL have parameter MAX_RETRY, default 3, number of failed lock attempts before fault.
REQ-006 SHALL have port i_clk, input, 1, free-running reference clock that also feeds the PLL.
REQ-007 SHALL have port i_rst, input, 1; reset is synchronous to i_clk and active-high.
REQ-008 SHALL have port i_locked, input, 1, PLL lock flag, asynchronous to i_clk.
REQ-009 SHALL have port o_pll_rst, output, 1, PLL reset request, active-high.
REQ-010 SHALL have port o_rst_periph, output, 1, peripheral-domain reset, active-high.
REQ-011 SHALL have port o_rst_core, output, 1, core-domain reset, active-high.
REQ-012 SHALL have port o_err, output, 1, sticky lock-failure flag.

Function
REQ-013 SHALL pass i_locked through a 2-flop synchronizer; all decisions use the synchronized value (lk).
REQ-014 SHALL implement states PLLRST, WAIT, FILTER, RELP, RUN, FAULT; all outputs registered.
REQ-015 PLLRST: o_pll_rst=1 for exactly PLL_RST_CYCLES cycles, then WAIT with the timeout counter cleared.
REQ-016 WAIT: lk=1 -> FILTER with the filter counter cleared; counter reaches LOCK_TIMEOUT-1 with lk=0 -> retry+1, then FAULT if retry reaches MAX_RETRY, else PLLRST.
REQ-017 FILTER: lk=0 on any cycle -> retry+1 and the same FAULT/PLLRST decision; LOCK_FILTER consecutive lk=1 cycles -> RELP.
REQ-018 RELP: o_rst_periph deasserts on the first cycle in RELP; after STAGE_DELAY cycles -> RUN, where o_rst_core deasserts; retry counter cleared on RUN entry.
REQ-019 lk=0 in RELP or RUN -> o_rst_periph and o_rst_core both reasserted on the next edge; then PLLRST.
REQ-020 Lock-loss latency: i_locked falling to o_rst_core high SHALL be at most 3 i_clk cycles.
REQ-021 FAULT: o_err=1, o_pll_rst=1, both domain resets asserted; exit only via i_rst.
REQ-022 o_rst_core SHALL never be low while o_rst_periph is high.
REQ-023 Counters SHALL be sized $clog2 of the largest parameter plus 1 and SHALL never wrap.

Reset
REQ-024 i_rst=1 SHALL force state PLLRST, o_pll_rst=1, o_rst_periph=1, o_rst_core=1, o_err=0, counters=0 and synchronizer=0 on the next edge, from any state including mid-sequence.

Configuration
REQ-025 With SERVANT_PLL_SUPERVISOR_STATUS_EN defined, the block SHALL add output o_relock_cnt, 8 bits, a saturating count of RUN->PLLRST lock-loss events, reset to 0 and saturating at 255.
REQ-026 Without SERVANT_PLL_SUPERVISOR_STATUS_EN, the block SHALL have no o_relock_cnt port and no associated logic.

Structure
REQ-027 The state encoding localparams and the lock-loss latency constant SHALL live in the shared package servant_pkg.
REQ-028 The 2-flop synchronizer SHALL be a separate sub-module, servant_sync2.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_FILTER=8, STAGE_DELAY=5, MAX_RETRY=2)
REQ-029 Nominal: i_locked rises 10 cycles after reset release -> o_pll_rst low at cycle 4; o_rst_periph falls 8 cycles after lk=1; o_rst_core falls 5 cycles later.
REQ-030 Timeout: i_locked held at 0 -> two PLLRST pulses of 4 cycles each, then o_err=1 after the second 20-cycle timeout, with all resets stuck high.
REQ-031 Glitch: i_locked high for 5 cycles then low during FILTER -> no reset release; PLLRST re-entered; retry count is 1.
REQ-032 Lock loss: i_locked drops in RUN -> o_rst_core and o_rst_periph high within 3 cycles; o_pll_rst pulses; sequence recovers; o_relock_cnt=1 when the macro is defined.
REQ-033 Mid-sequence reset: i_rst pulsed during RELP -> all resets high next cycle, o_err=0, and the sequence restarts from PLLRST.
REQ-034 Ordering: a checker SHALL confirm REQ-022 holds on every cycle of all scenarios above.
